// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex 7-segment driver with tear-free frame commit
module seven_seg_scanner #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blink_en,
   input  logic                  blank_lz,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_tick
);
   localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam int SW = 6 * DIGITS;

   logic [PW-1:0]       pcnt;
   logic [IW-1:0]       idx;
   logic [BW-1:0]       fcnt;
   logic                phase;
   logic [SW-1:0]       pend, act;
   logic [4*DIGITS-1:0] act_val;
   logic [DIGITS-1:0]   act_dp, act_bl;
   logic                slot_end, boundary, last_frame;
   logic [3:0]          nib;
   logic                zero_above, lz_blank, blinked;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b0000001;
         4'h1: decode = 7'b1001111;
         4'h2: decode = 7'b0010010;
         4'h3: decode = 7'b0000110;
         4'h4: decode = 7'b1001100;
         4'h5: decode = 7'b0100100;
         4'h6: decode = 7'b0100000;
         4'h7: decode = 7'b0001111;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0000100;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b1100000;
         4'hC: decode = 7'b0110001;
         4'hD: decode = 7'b1000010;
         4'hE: decode = 7'b0110000;
         4'hF: decode = 7'b0111000;
      endcase
   endfunction

   assign slot_end   = pcnt == PW'(REFRESH_DIV - 1);
   assign boundary   = slot_end && idx == IW'(DIGITS - 1);
   assign last_frame = fcnt == BW'(BLINK_FRAMES - 1);
   assign act_val    = act[SW-1:2*DIGITS];
   assign act_dp     = act[2*DIGITS-1:DIGITS];
   assign act_bl     = act[DIGITS-1:0];
   assign nib        = act_val[4*idx +: 4];
   assign blinked    = phase && act_bl[idx];

   // a digit is a leading zero when it and every more significant nibble are zero; digit 0 always shows
   always_comb begin
      zero_above = 1'b1;
      lz_blank   = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && act_val[4*k +: 4] == 4'd0;
         if (k == int'(idx)) lz_blank = blank_lz && zero_above && k != 0;
      end
   end

   // slot prescaler, digit index and blink phase (phase flips every BLINK_FRAMES frames)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt  <= '0;
         idx   <= '0;
         fcnt  <= '0;
         phase <= 1'b0;
      end else begin
         pcnt <= slot_end ? '0 : pcnt + 1'b1;
         if (slot_end) idx <= boundary ? '0 : idx + 1'b1;
         if (boundary) begin
            fcnt  <= last_frame ? '0 : fcnt + 1'b1;
            phase <= phase ^ last_frame;
         end
      end
   end

   // pending captures every load; active only changes at a frame boundary, bypassing a coincident load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         act  <= '0;
      end else begin
         if (load) pend <= {value_in, dp_in, blink_en};
         if (boundary) act <= load ? {value_in, dp_in, blink_en} : pend;
      end
   end

   // registered pin drivers so anode and segments always change on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out    <= 7'b1111111;
         dp_out     <= 1'b1;
         an_out     <= '1;
         frame_tick <= 1'b0;
      end else begin
         seg_out    <= (lz_blank || blinked) ? 7'b1111111 : decode(nib);
         dp_out     <= blinked || !act_dp[idx];
         an_out     <= ~(DIGITS'(1) << idx);
         frame_tick <= boundary;
      end
   end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized check of the scanner against a cycle-count based model
module tb_seven_seg_scanner;
   localparam int D = 4, RD = 4, BF = 2, F = D * RD;

   logic        clk = 1'b0, rst = 1'b0;
   logic [15:0] value_in = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_in = '0, blink_en = '0;
   logic        blank_lz = 1'b0;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;
   logic        frame_tick;

   int errors = 0, checks = 0;
   logic armed = 1'b0;

   logic [6:0] dec [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   int          e, commits;
   logic [15:0] pv, av;
   logic [3:0]  pd, pb, ad, ab;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_tick;
   logic [3:0]  exp_an;

   seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .load(load), .dp_in(dp_in),
      .blink_en(blink_en), .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out),
      .an_out(an_out), .frame_tick(frame_tick));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
      end
   endtask

   // model: edge e (1-based since reset) shows digit ((e-1)/RD)%D; every F-th edge commits
   always @(posedge clk or posedge rst) begin
      int k;
      logic bl;
      if (rst) begin
         e = 0; commits = 0; pv = 0; pd = 0; pb = 0; av = 0; ad = 0; ab = 0;
         exp_seg = 7'h7f; exp_dp = 1'b1; exp_an = 4'hf; exp_tick = 1'b0;
      end else begin
         e++;
         k = ((e - 1) / RD) % D;
         bl = ((commits / BF) % 2 == 1) && ab[k];
         exp_an = ~(4'b0001 << k);
         exp_seg = (bl || (blank_lz && k != 0 && (av >> (4 * k)) == 16'h0)) ? 7'h7f : dec[av[4*k +: 4]];
         exp_dp = bl || !ad[k];
         exp_tick = (e % F == 0);
         if (load) begin pv = value_in; pd = dp_in; pb = blink_en; end
         if (exp_tick) begin av = pv; ad = pd; ab = pb; commits++; end
      end
   end

   always @(negedge clk)
      if (armed) chk("scan", {seg_out, dp_out, an_out, frame_tick}, {exp_seg, exp_dp, exp_an, exp_tick});

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      @(negedge clk);
      value_in = v; dp_in = d; blink_en = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_tick();
      logic found = 1'b0;
      for (int i = 0; i < 3 * F && !found; i++) begin
         @(negedge clk);
         found = frame_tick;
      end
      chk("tick_wait", found, 1);
   endtask

   task automatic wait_an(input int k);
      logic found = 1'b0;
      for (int i = 0; i < 3 * F && !found; i++) begin
         @(negedge clk);
         found = an_out == ~(4'b0001 << k);
      end
      chk("an_wait", found, 1);
   endtask

   task automatic look(input int k, input string n, input logic [6:0] s);
      wait_an(k);
      chk(n, seg_out, s);
   endtask

   initial begin
      logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
      logic found;
      #1 rst = 1'b1;
      armed = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("an_first", an_out, 4'b1110);
      repeat (4) @(negedge clk);
      chk("an_second", an_out, 4'b1101);
      do_load(16'hA5C0, 4'b0000, 4'b0000);
      wait_tick();
      look(0, "dec_d0", 7'b0000001);
      look(1, "dec_d1", 7'b0110001);
      look(2, "dec_d2", 7'b0100100);
      look(3, "dec_d3", 7'b0001000);
      foreach (sweep[i]) begin
         do_load(sweep[i], 4'b0000, 4'b0000);
         repeat (2 * F) @(negedge clk);
      end
      blank_lz = 1'b1;
      do_load(16'h0070, 4'b0000, 4'b0000);
      wait_tick();
      look(0, "lz_d0", 7'b0000001);
      look(1, "lz_d1", 7'b0001111);
      look(2, "lz_d2", 7'b1111111);
      look(3, "lz_d3", 7'b1111111);
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_tick();
      look(0, "zero_d0", 7'b0000001);
      look(1, "zero_d1", 7'b1111111);
      blank_lz = 1'b0;
      wait_tick();
      repeat (5) @(negedge clk);
      do_load(16'h1234, 4'b0000, 4'b0000);
      wait_tick();
      look(0, "commit_d0", 7'b1001100);
      found = 1'b0;
      for (int i = 0; i < F && !found; i++) begin
         @(negedge clk);
         found = (e + 1) % F == 0;
      end
      value_in = 16'h9876; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      look(0, "bypass_d0", 7'b0100000);
      do_load(16'h1111, 4'b0100, 4'b0010);
      wait_tick();
      wait_an(2);
      chk("dp_d2", dp_out, 0);
      repeat (8 * F) @(negedge clk);
      repeat (800) begin
         @(negedge clk);
         load = $urandom_range(0, 7) == 0;
         value_in = 16'($urandom);
         dp_in = 4'($urandom);
         blink_en = 4'($urandom);
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      end
      load = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_async", {seg_out, dp_out, an_out, frame_tick}, {7'h7f, 1'b1, 4'hf, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("an_restart", an_out, 4'b1110);
      repeat (3 * F) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display in the clock practice design. It latches a packed hex value on a load strobe and commits it only at frame boundaries, so the display never tears. It scans one digit per refresh slot and decodes hex 0-F to active-low segments. It adds per-digit decimal points, leading-zero blanking and per-digit blink, and sits between the time-keeping counters and the board pins.

## Interface
- DIGITS, 4: number of multiplexed digits, legal 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, legal ≥1.
- BLINK_FRAMES, 64: full scan frames per blink half-period, legal ≥1.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  4*DIGITS  packed nibbles; digit 0 = bits [3:0], the least significant digit.
- load  in  1  one-cycle strobe; captures value_in, dp_in and blink_en into the pending register.
- dp_in  in  DIGITS  per-digit decimal point request, 1 = lit.
- blink_en  in  DIGITS  per-digit blink enable.
- blank_lz  in  1  level; 1 = suppress leading zeros. Sampled live, not through load.
- seg_out  out  7  active-low segments {a,b,c,d,e,f,g}, with a = bit 6 and g = bit 0.
- dp_out  out  1  active-low decimal point.
- an_out  out  DIGITS  active-low digit enables, one-hot-low.
- frame_tick  out  1  one-cycle pulse at each frame commit.

## Operation
- **Prescaler** `pcnt` counts 0..REFRESH_DIV-1 and wraps. At wrap, scan index `idx` advances 0..DIGITS-1 and wraps to 0.
- **Frame boundary:** the cycle in which `idx` wraps DIGITS-1→0.
  - At the boundary, active ← pending and frame_tick = 1 for that cycle.
  - frame_tick is registered with the commit.
- **Pending register:** load = 1 writes pending. If load coincides with a frame boundary, active takes value_in/dp_in/blink_en directly (bypass), and pending is also written.
- **Decode:** each nibble maps to active-low codes, listed as {a..g}:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- **Leading-zero blank:**
  - With blank_lz = 1, digit k is blanked when every active nibble from DIGITS-1 down to k is 0.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
  - A blanked digit drives seg = 1111111, but its decimal point still follows dp.
- **Blink:**
  - `phase` toggles every BLINK_FRAMES frame boundaries.
  - While phase = 1, digits with active blink_en drive seg = 1111111 and dp_out = 1.
- **Outputs** for the current digit, all registered:
  - an_out = ~(1<<idx).
  - seg_out = decode, blank or blink result.
  - dp_out = ~dp_active[idx], forced to 1 when blinked.
- **Reset** (asynchronous, immediate):
  - seg_out = 7'b1111111, dp_out = 1, an_out = all ones, frame_tick = 0.
  - pcnt, idx, phase = 0; pending and active = 0.
- **Reset mid-frame:** all state clears; scanning restarts at digit 0 and any pending load is lost.

## Timing
- Outputs are registered from `idx` and active state. The first rising edge after rst falls drives an_out for digit 0.
- Each digit is enabled for exactly REFRESH_DIV cycles. A frame lasts DIGITS*REFRESH_DIV cycles.
- an_out changes in the same cycle that seg_out and dp_out change, so there is no cycle with the wrong segments on an enabled anode.
- **Load to display latency:** up to one frame.
  - New data appears on digit 0 in the cycle after the committing boundary.
  - frame_tick is asserted in the boundary cycle itself.
- REFRESH_DIV = 1 gives one digit per cycle. DIGITS = 1 gives a boundary every REFRESH_DIV cycles, and an_out stays 0.
- Multiple loads within one frame: the last one wins.
- blank_lz takes effect on the next output update (1 cycle).

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.

1. **Reset:** assert rst mid-scan -> same cycle: seg_out=1111111, an_out=1111, dp_out=1. After release, an_out=1110 for 4 cycles, then 1101.
2. **Decode and scan:** load value 16'hA5C0 -> after the next frame_tick, digits 0..3 show 0000001, 0110001, 0100100, 0001000, each for 4 cycles. Sweep all 16 nibbles.
3. **Leading-zero blank:**
   - blank_lz=1 with value 16'h0070 -> digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001.
   - Value 16'h0000 -> only digit 0 is lit.
4. **Tear-free commit:** load 16'h1234 at cycle 5 of a frame -> display keeps old data until the boundary, then shows 4,3,2,1. A load on the boundary cycle appears in the very next frame (bypass).
5. **Blink and dp:** blink_en=4'b0010, dp_in=4'b0100 -> digit 1 is dark for 2 frames and lit for 2, repeating. Digit 2 has dp_out=0 while enabled.
6. **frame_tick:** exactly one pulse every 16 cycles, coincident with the idx 3→0 wrap and absent during reset.
